fu_writeback_queue: RTL and testbench

//  Per-functional-unit result buffering between the FU pipelines and the common data bus.

---
 rtl/wbq_pkg.sv | 26 ++
 rtl/fu_writeback_queue_if.sv | 32 +++
 rtl/wbq_fifo.sv | 52 +++++
 rtl/fu_writeback_queue.sv | 127 ++++++++++++
 tb/tb_fu_writeback_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbq_pkg.sv
// Shared types and sizes for the per-FU writeback queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wbq_pkg;

    localparam int XLEN         = 32;
    localparam int RS_TAG_WIDTH = 4;
    localparam int NUM_FUS      = 5;
    localparam int DEPTH        = 4;   // power of 2, >= 2

    localparam int FU_ID_W = $clog2(NUM_FUS);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OCC_W   = $clog2(NUM_FUS * DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]         result;
        logic [RS_TAG_WIDTH-1:0] tag;
    } wb_entry_t;

    // Round-robin successor of an FU index, wrapping after the last FU.
    function automatic logic [FU_ID_W-1:0] next_fu_id(input logic [FU_ID_W-1:0] id);
        return (id == FU_ID_W'(NUM_FUS - 1)) ? '0 : id + FU_ID_W'(1);
    endfunction

endpackage

// File: rtl/fu_writeback_queue_if.sv
// FU producer ports plus the CDB-facing valid/ready port of the writeback queue.
// Latency: n/a (wiring only).
// Backpressure: fu_ready per FU toward producers, wb_ready from the CDB.
// Modports: master = FU/CDB side (drives requests and wb_ready),
//           slave  = the queue (drives fu_ready, wb_* and occupancy).
interface fu_writeback_queue_if;
    import wbq_pkg::*;

    logic [NUM_FUS-1:0]                   fu_valid;
    logic [NUM_FUS-1:0][XLEN-1:0]         fu_result;
    logic [NUM_FUS-1:0][RS_TAG_WIDTH-1:0] fu_tag;
    logic [NUM_FUS-1:0]                   fu_ready;

    logic                                 wb_valid;
    logic [XLEN-1:0]                      wb_result;
    logic [RS_TAG_WIDTH-1:0]              wb_tag;
    logic [FU_ID_W-1:0]                   wb_fu_id;
    logic                                 wb_ready;

    logic [OCC_W-1:0]                     occupancy;

    modport master (
        output fu_valid, fu_result, fu_tag, wb_ready,
        input  fu_ready, wb_valid, wb_result, wb_tag, wb_fu_id, occupancy
    );

    modport slave (
        input  fu_valid, fu_result, fu_tag, wb_ready,
        output fu_ready, wb_valid, wb_result, wb_tag, wb_fu_id, occupancy
    );

endinterface

// File: rtl/wbq_fifo.sv
// Single-FU result FIFO with synchronous rst and flush (flush outranks push/pop).
// Latency: a push is visible at dout/count the cycle after its edge.
// Backpressure: full from registered count; push while full and pop while empty are ignored.
// Ports: clk, rst, flush, push, pop, din -> dout (head), count, full, empty.
module wbq_fifo import wbq_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fu_writeback_queue.sv
// Per-FU result FIFOs arbitrated onto the CDB through one valid/ready port.
// Latency: push at edge N is presentable in cycle N+1; output is combinational from FIFO heads.
// Backpressure: an FU stalls only when its own FIFO is full; a stalled grant stays locked.
// Ports: clk, rst (sync, active-high), flush, bus (fu_writeback_queue_if.slave).
// Build option: define WBQ_ROUND_ROBIN_EN for round-robin grant; otherwise lowest FU index wins.
module fu_writeback_queue import wbq_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    fu_writeback_queue_if.slave bus
);

    wb_entry_t          head     [NUM_FUS];
    logic [CNT_W-1:0]   fifo_cnt [NUM_FUS];
    logic [NUM_FUS-1:0] fifo_full;
    logic [NUM_FUS-1:0] fifo_empty;
    logic [NUM_FUS-1:0] fifo_push;
    logic [NUM_FUS-1:0] fifo_pop;

    logic               any_vld;
    logic               handshake;
    logic [FU_ID_W-1:0] arb_id;
    logic [FU_ID_W-1:0] grant_id;
    logic               lock_vld;
    logic [FU_ID_W-1:0] lock_id;
    logic [OCC_W-1:0]   occ_sum;

    // fu_ready comes straight from registered count, so a same-cycle pop
    // never opens a slot combinationally.
    assign bus.fu_ready = ~fifo_full;
    assign fifo_push    = bus.fu_valid & ~fifo_full;

    for (genvar g = 0; g < NUM_FUS; g++) begin : g_fifo
        wb_entry_t din_g;
        assign din_g = '{result: bus.fu_result[g], tag: bus.fu_tag[g]};

        wbq_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (din_g),
            .dout  (head[g]),
            .count (fifo_cnt[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign any_vld   = |(~fifo_empty);
    assign handshake = any_vld && bus.wb_ready;

`ifdef WBQ_ROUND_ROBIN_EN
    logic [FU_ID_W-1:0] rr_ptr;

    // Walk from the farthest candidate back to rr_ptr so the closest
    // non-empty FIFO at or after rr_ptr is the last (winning) assignment.
    always_comb begin
        int                 idx;
        logic [FU_ID_W-1:0] cand;
        arb_id = '0;
        idx    = 0;
        cand   = '0;
        for (int k = NUM_FUS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FUS) idx = idx - NUM_FUS;
            cand = FU_ID_W'(idx);
            if (!fifo_empty[cand]) arb_id = cand;
        end
    end

    // A flushed handshake never happened, so the pointer only moves on a real pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (handshake && !flush) begin
            rr_ptr <= next_fu_id(grant_id);
        end
    end
`else
    // Fixed priority: descending scan leaves the lowest non-empty index.
    always_comb begin
        arb_id = '0;
        for (int i = NUM_FUS - 1; i >= 0; i--) begin
            if (!fifo_empty[FU_ID_W'(i)]) arb_id = FU_ID_W'(i);
        end
    end
`endif

    // A stalled presentation keeps its FIFO; the locked FIFO cannot drain
    // while locked, so lock_id always points at a non-empty FIFO.
    assign grant_id = lock_vld ? lock_id : arb_id;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else begin
            lock_vld <= any_vld && !bus.wb_ready;
            lock_id  <= grant_id;
        end
    end

    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            fifo_pop[i] = handshake && (grant_id == FU_ID_W'(i));
        end
    end

    assign bus.wb_valid  = any_vld;
    assign bus.wb_fu_id  = any_vld ? grant_id : '0;
    assign bus.wb_result = any_vld ? head[grant_id].result : '0;
    assign bus.wb_tag    = any_vld ? head[grant_id].tag : '0;

    // Sum of the registered counts, so it moves with the same edge's pushes and pops.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            occ_sum = occ_sum + OCC_W'(fifo_cnt[i]);
        end
    end

    assign bus.occupancy = occ_sum;

endmodule

// File: tb/tb_fu_writeback_queue.sv
// Self-checking bench for fu_writeback_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
// Honours WBQ_ROUND_ROBIN_EN the same way the design does.
module tb_fu_writeback_queue;
    import wbq_pkg::*;

    logic clk;
    logic rst;
    logic flush;

    fu_writeback_queue_if bus();

    fu_writeback_queue dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue of entries per FU, the round-robin pointer and
    // the FU that was left waiting by a stalled CDB.
    wb_entry_t mq [NUM_FUS][$];
    int        m_rr;
    bit        m_lock;
    int        m_lock_id;

    int n_checks;
    int n_errors;

    function automatic int exp_occ();
        int s = 0;
        for (int i = 0; i < NUM_FUS; i++) s += mq[i].size();
        return s;
    endfunction

    function automatic logic [NUM_FUS-1:0] exp_ready();
        logic [NUM_FUS-1:0] r;
        for (int i = 0; i < NUM_FUS; i++) r[i] = (mq[i].size() != DEPTH);
        return r;
    endfunction

    // FU index expected on the CDB this cycle, -1 when nothing is buffered.
    function automatic int exp_grant();
        if (exp_occ() == 0) return -1;
        if (m_lock) return m_lock_id;
`ifdef WBQ_ROUND_ROBIN_EN
        for (int k = 0; k < NUM_FUS; k++) begin
            if (mq[(m_rr + k) % NUM_FUS].size() > 0) return (m_rr + k) % NUM_FUS;
        end
`else
        for (int i = 0; i < NUM_FUS; i++) begin
            if (mq[i].size() > 0) return i;
        end
`endif
        return -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_FUS; i++) mq[i].delete();
        m_lock = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        int                 g;
        logic [NUM_FUS-1:0] rdy;
        bit                 hs;
        g   = exp_grant();
        rdy = exp_ready();
        hs  = (g >= 0) && bus.wb_ready;
        @(posedge clk);
        if (rst) begin
            clear_model();
            m_rr = 0;
        end else if (flush) begin
            clear_model();
        end else begin
            if (hs) begin
                void'(mq[g].pop_front());
                m_rr = (g + 1) % NUM_FUS;
            end
            for (int i = 0; i < NUM_FUS; i++) begin
                if (bus.fu_valid[i] && rdy[i])
                    mq[i].push_back('{result: bus.fu_result[i], tag: bus.fu_tag[i]});
            end
            m_lock    = (g >= 0) && !bus.wb_ready;
            m_lock_id = g;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        flush        = 1'b0;
        bus.fu_valid = '0;
        bus.wb_ready = 1'b0;
        for (int i = 0; i < NUM_FUS; i++) begin
            bus.fu_result[i] = XLEN'($urandom);
            bus.fu_tag[i]    = RS_TAG_WIDTH'($urandom);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst          = 1'b1;
        bus.fu_valid = '1;
        #1; tick(); tick();
        rst          = 1'b0;
        bus.fu_valid = '0;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_wb_valid got %0b want 0", bus.wb_valid);
        end
        n_checks++;
        if (bus.fu_ready !== 5'b11111) begin
            n_errors++; $display("FAIL reset_fu_ready got %b want 11111", bus.fu_ready);
        end
        n_checks++;
        if (bus.occupancy !== '0) begin
            n_errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy);
        end
        n_checks++;
        if (bus.wb_fu_id !== '0 || bus.wb_tag !== '0 || bus.wb_result !== '0) begin
            n_errors++; $display("FAIL reset_wb_fields got id=%0d tag=%0d res=%h want 0",
                                 bus.wb_fu_id, bus.wb_tag, bus.wb_result);
        end
        tick();
    endtask

    task automatic test_single_push();
        bus.fu_valid     = 5'b00100;
        bus.fu_result[2] = 32'hDEADBEEF;
        bus.fu_tag[2]    = 4'd3;
        bus.wb_ready     = 1'b1;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_pre_valid got %0b want 0", bus.wb_valid);
        end
        tick();
        bus.fu_valid = '0;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_fu_id !== 3'd2 || bus.wb_tag !== 4'd3 ||
            bus.wb_result !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL single_present got v=%0b id=%0d tag=%0d res=%h want 1 2 3 deadbeef",
                                 bus.wb_valid, bus.wb_fu_id, bus.wb_tag, bus.wb_result);
        end
        tick();
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_drained got %0b want 0", bus.wb_valid);
        end
    endtask

    task automatic test_fill();
        bus.wb_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.fu_valid  = 5'b00010;
            bus.fu_tag[1] = RS_TAG_WIDTH'(k + 1);
            #1; tick();
        end
        bus.fu_tag[1] = 4'd5;
        #1;
        n_checks++;
        if (bus.fu_ready[1] !== 1'b0 || bus.occupancy !== 5'd4) begin
            n_errors++; $display("FAIL fill_full got rdy1=%0b occ=%0d want 0 4", bus.fu_ready[1], bus.occupancy);
        end
        tick();
        bus.fu_valid = '0;
        #1;
        n_checks++;
        if (bus.occupancy !== 5'd4) begin
            n_errors++; $display("FAIL fill_fifth_ignored got occ=%0d want 4", bus.occupancy);
        end
        bus.wb_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_fu_id !== 3'd1 || bus.wb_tag !== RS_TAG_WIDTH'(k + 1)) begin
                n_errors++; $display("FAIL fill_drain_%0d got v=%0b id=%0d tag=%0d want 1 1 %0d",
                                     k, bus.wb_valid, bus.wb_fu_id, bus.wb_tag, k + 1);
            end
            tick();
        end
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.fu_ready !== 5'b11111) begin
            n_errors++; $display("FAIL fill_empty got v=%0b rdy=%b want 0 11111", bus.wb_valid, bus.fu_ready);
        end
    endtask

    task automatic test_stall_lock();
        bus.wb_ready  = 1'b0;
        bus.fu_valid  = 5'b01000;
        bus.fu_tag[3] = 4'd7;
        #1; tick();
        bus.fu_valid  = 5'b00001;
        bus.fu_tag[0] = 4'd9;
        #1; tick();
        bus.fu_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_fu_id !== 3'd3 || bus.wb_tag !== 4'd7) begin
                n_errors++; $display("FAIL stall_hold_%0d got v=%0b id=%0d tag=%0d want 1 3 7",
                                     k, bus.wb_valid, bus.wb_fu_id, bus.wb_tag);
            end
            tick();
        end
        bus.wb_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.wb_fu_id !== 3'd3) begin
            n_errors++; $display("FAIL stall_release got id=%0d want 3", bus.wb_fu_id);
        end
        tick();
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_fu_id !== 3'd0 || bus.wb_tag !== 4'd9) begin
            n_errors++; $display("FAIL stall_next got v=%0b id=%0d tag=%0d want 1 0 9",
                                 bus.wb_valid, bus.wb_fu_id, bus.wb_tag);
        end
        tick();
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_empty got %0b want 0", bus.wb_valid);
        end
    endtask

    task automatic test_arbitration();
`ifdef WBQ_ROUND_ROBIN_EN
        int exp_order [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
`else
        int exp_order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
`endif
        rst = 1'b1;
        #1; tick();
        rst          = 1'b0;
        bus.wb_ready = 1'b0;
        bus.fu_valid = 5'b11111;
        for (int i = 0; i < NUM_FUS; i++) bus.fu_tag[i] = RS_TAG_WIDTH'(i);
        #1; tick(); tick();
        bus.fu_valid = '0;
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (bus.wb_valid !== 1'b1 || bus.wb_fu_id !== FU_ID_W'(exp_order[k]) ||
                bus.wb_tag !== RS_TAG_WIDTH'(exp_order[k])) begin
                n_errors++; $display("FAIL arb_order_%0d got v=%0b id=%0d want id %0d",
                                     k, bus.wb_valid, bus.wb_fu_id, exp_order[k]);
            end
            tick();
        end
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.occupancy !== '0) begin
            n_errors++; $display("FAIL arb_empty got v=%0b occ=%0d want 0 0", bus.wb_valid, bus.occupancy);
        end
    endtask

    task automatic test_flush();
        bus.wb_ready = 1'b0;
        bus.fu_valid = 5'b11111;
        #1; tick();
        bus.fu_valid = 5'b00011;
        #1; tick();
        bus.fu_valid = '0;
        #1;
        n_checks++;
        if (bus.occupancy !== 5'd7) begin
            n_errors++; $display("FAIL flush_pre_occ got %0d want 7", bus.occupancy);
        end
        flush        = 1'b1;
        bus.fu_valid = 5'b10000;
        bus.wb_ready = 1'b1;
        #1; tick();
        flush        = 1'b0;
        bus.fu_valid = '0;
        #1;
        n_checks++;
        if (bus.occupancy !== '0 || bus.wb_valid !== 1'b0 || bus.fu_ready !== 5'b11111) begin
            n_errors++; $display("FAIL flush_clear got occ=%0d v=%0b rdy=%b want 0 0 11111",
                                 bus.occupancy, bus.wb_valid, bus.fu_ready);
        end
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 800; c++) begin
            rst          = ($urandom_range(0, 249) == 0);
            flush        = ($urandom_range(0, 59) == 0);
            bus.fu_valid = NUM_FUS'($urandom);
            bus.wb_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_FUS; i++) begin
                bus.fu_result[i] = XLEN'($urandom);
                bus.fu_tag[i]    = RS_TAG_WIDTH'($urandom);
            end
            #1;
            g = exp_grant();
            n_checks++;
            if (bus.wb_valid !== (g >= 0)) begin
                n_errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, bus.wb_valid, g >= 0);
            end
            if (g >= 0) begin
                n_checks++;
                if (bus.wb_fu_id !== FU_ID_W'(g) || bus.wb_tag !== mq[g][0].tag ||
                    bus.wb_result !== mq[g][0].result) begin
                    n_errors++; $display("FAIL rand_head cyc %0d got id=%0d tag=%0d res=%h want %0d %0d %h",
                                         c, bus.wb_fu_id, bus.wb_tag, bus.wb_result,
                                         g, mq[g][0].tag, mq[g][0].result);
                end
            end
            n_checks++;
            if (bus.fu_ready !== exp_ready() || bus.occupancy !== OCC_W'(exp_occ())) begin
                n_errors++; $display("FAIL rand_state cyc %0d got rdy=%b occ=%0d want %b %0d",
                                     c, bus.fu_ready, bus.occupancy, exp_ready(), exp_occ());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_rr      = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        idle_inputs();
        test_reset();
        test_single_push();
        test_fill();
        test_stall_lock();
        test_arbitration();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
